// File: rtl/vector_pkg.sv
// vector_pkg: shared types and helpers for the vector serializer slice
package vector_pkg;
  localparam int MAX_VEC_W = 4096;
  typedef enum logic {EMPTY = 1'b0, EMIT = 1'b1} state_t;
  function automatic int LANE_IDX_W(input int lanes);
    return $clog2(lanes);
  endfunction
  // Lane k of a packed vector lands in the low w bits; caller truncates to w
  function automatic logic [MAX_VEC_W-1:0] lane_slice(input logic [MAX_VEC_W-1:0] vec, input int w, input int k);
    return vec >> (k * w);
  endfunction
endpackage

// File: rtl/vector_fifo_nir.sv
// vector_fifo_nir: circular sync FIFO with count and same-cycle write+read
module vector_fifo_nir #(
  parameter int W = 44,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_wr, do_rd;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_rd = en & rd & ~empty;
  assign do_wr = en & wr & (~full | do_rd);
  assign rdata = mem[rptr];
  // pointer and occupancy bookkeeping; a full FIFO may refill in the cycle it pops
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= nxt(wptr);
      if (do_rd) rptr <= nxt(rptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  // storage array; contents are meaningless while count is zero so no reset
  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= wdata;
endmodule

// File: rtl/vector_serializer_nir.sv
// vector_serializer_nir: buffers adder result vectors and emits them lane by lane
module vector_serializer_nir
  import vector_pkg::*;
#(
  parameter int IN_WIDTH = 11,
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          inReady,
  input  logic [LANES*IN_WIDTH-1:0]     I,
  output logic                          inAccept,
  output logic                          outReady,
  output logic [IN_WIDTH-1:0]           out,
  output logic [LANE_IDX_W(LANES)-1:0]  outIndex,
  output logic                          outLast,
  input  logic                          outAck,
  output logic                          overflow
);
  localparam int VW = LANES*IN_WIDTH;
  localparam int IW = LANE_IDX_W(LANES);
  localparam int CW = $clog2(DEPTH+1);
  state_t state;
  logic [IW-1:0] lane_idx;
  logic [VW-1:0] head;
  logic [CW-1:0] count;
  logic full, empty, advance, last, pop, wr, drop;
  assign advance  = enable & outReady & outAck;
  assign last     = lane_idx == IW'(LANES-1);
  assign pop      = advance & last & ~empty;
  assign inAccept = ~full | pop;
  assign wr       = enable & inReady & inAccept;
  assign drop     = enable & inReady & ~inAccept;
  assign outReady = state == EMIT;
  assign outIndex = outReady ? lane_idx : '0;
  assign outLast  = outReady & last;
  assign out      = outReady ? IN_WIDTH'(lane_slice(MAX_VEC_W'(head), IN_WIDTH, int'(lane_idx))) : '0;
  vector_fifo_nir #(.W(VW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .wr    (wr),
    .rd    (pop),
    .wdata (I),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // emit FSM and lane counter; EMIT exactly while at least one vector is buffered
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= EMPTY;
      lane_idx <= '0;
    end else if (enable) begin
      state <= (state == EMPTY) ? (wr ? EMIT : EMPTY) : ((pop && count == CW'(1) && !wr) ? EMPTY : EMIT);
      if (advance) lane_idx <= last ? '0 : lane_idx + 1'b1;
    end
  // sticky drop flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
endmodule
